// File: rtl/alux_pkg.sv
// Shared definitions for the ALUX issuer: opcode map, FSM encoding and
// the opcode legality check.
package alux_pkg;

  localparam int OPR_W = 4;

  localparam logic [OPR_W-1:0] OPR_A    = 4'b0000;
  localparam logic [OPR_W-1:0] OPR_B    = 4'b0001;
  localparam logic [OPR_W-1:0] OPR_ADD  = 4'b0010;
  localparam logic [OPR_W-1:0] OPR_SUB  = 4'b0011;
  localparam logic [OPR_W-1:0] OPR_MUL  = 4'b0100;
  localparam logic [OPR_W-1:0] OPR_REIM = 4'b0110;
  localparam logic [OPR_W-1:0] OPR_EQ   = 4'b1000;
  localparam logic [OPR_W-1:0] OPR_MODA = 4'b1001;
  localparam logic [OPR_W-1:0] OPR_MODB = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_legal_opr(input logic [OPR_W-1:0] opr);
    case (opr)
      OPR_A, OPR_B, OPR_ADD, OPR_SUB, OPR_MUL,
      OPR_REIM, OPR_EQ, OPR_MODA, OPR_MODB: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alux_issuer_wdog.sv
// WAIT-state watchdog. Loaded in ISSUE, counts down once per WAIT cycle and
// flags expiry during the TIMEOUT-th WAIT cycle.
module alux_issuer_wdog #(
  parameter int TIMEOUT = 63
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Down-counter; holds at zero so it can never wrap if left enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= CNT_W'(TIMEOUT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/alux_issuer.sv
// Command issuer for the ALUX complex ALU. Accepts tagged commands, pulses
// start, waits for done (with watchdog) and returns a tagged response.
//
// state    | meaning
// ST_IDLE  | ready for a command
// ST_ISSUE | start pulse on the ALU, watchdog loaded
// ST_WAIT  | waiting for alu_done or timeout
// ST_RESP  | response held until downstream takes it
module alux_issuer
  import alux_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPR_W-1:0]  cmd_opr,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_inA,
  output logic [DATA_W-1:0] alu_inB,
  output logic [OPR_W-1:0]  alu_opr,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_outAB,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       ops_count,
  output logic [7:0]        err_count
);

  state_t            state_q;
  logic              cmd_ready_q;
  logic [DATA_W-1:0] alu_inA_q;
  logic [DATA_W-1:0] alu_inB_q;
  logic [OPR_W-1:0]  alu_opr_q;
  logic              alu_start_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              rsp_err_q;
  logic [15:0]       ops_cnt_q;
  logic [7:0]        err_cnt_q;
  logic [7:0]        err_cnt_d;
  logic              wd_expired;

  alux_issuer_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (state_q == ST_ISSUE),
    .en_i      (state_q == ST_WAIT),
    .expired_o (wd_expired)
  );

  // Saturating error count increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Issuer FSM with registered handshake, ALU drive and response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      alu_inA_q   <= '0;
      alu_inB_q   <= '0;
      alu_opr_q   <= '0;
      alu_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      ops_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      alu_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            rsp_tag_q   <= cmd_tag;
            if (is_legal_opr(cmd_opr)) begin
              alu_inA_q   <= cmd_a;
              alu_inB_q   <= cmd_b;
              alu_opr_q   <= cmd_opr;
              alu_start_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end else begin
              // Illegal opcode never reaches the ALU.
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              err_cnt_q   <= err_cnt_d;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          // alu_done seen here belongs to a previous operation.
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_done) begin
            rsp_data_q  <= alu_outAB;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            ops_cnt_q   <= ops_cnt_q + 16'd1;
            state_q     <= ST_RESP;
          end else if (wd_expired) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            err_cnt_q   <= err_cnt_d;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_inA   = alu_inA_q;
  assign alu_inB   = alu_inB_q;
  assign alu_opr   = alu_opr_q;
  assign alu_start = alu_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign ops_count = ops_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_alux_issuer.sv
// Directed bench for alux_issuer; the bench acts as upstream, ALU and
// downstream. Inputs change and outputs are sampled on the falling edge.
module tb_alux_issuer;
  import alux_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opr = '0;
  logic [63:0] cmd_a = '0;
  logic [63:0] cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic [63:0] alu_inA, alu_inB;
  logic [3:0]  alu_opr;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [63:0] alu_outAB = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;
  logic [15:0] ops_count;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;

  alux_issuer #(.DATA_W(64), .TAG_W(4), .TIMEOUT(63)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opr(cmd_opr),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_opr(alu_opr),
    .alu_start(alu_start), .alu_done(alu_done), .alu_outAB(alu_outAB),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy),
    .ops_count(ops_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command and return at the falling edge of the start cycle.
  task automatic issue(input logic [3:0] opr, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] tag);
    int g = 0;
    while (!cmd_ready && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_opr   = opr;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_opr   = 4'hF;
    cmd_a     = 64'hBAD0_BAD0_BAD0_BAD0;
    cmd_tag   = 4'hF;
  endtask

  // ALU model: done sampled N cycles after the start cycle, result val.
  task automatic alu_respond(input int n, input logic [63:0] val);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i == 0) chk("start_one_cycle", alu_start, 0);
    end
    chk("valid_before_done", rsp_valid, 0);
    alu_done  = 1'b1;
    alu_outAB = val;
    @(negedge clock);
    alu_done  = 1'b0;
    alu_outAB = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    logic [63:0] a, b, r;
    logic [63:0] held_data;
    int cnt;

    // Reset state
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops_count, 0);
    chk("rst_errs", err_count, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("ready_before_edge", cmd_ready, 0);
    @(negedge clock);
    chk("ready_after_edge", cmd_ready, 1);

    // 1. Passthrough, done after 1 cycle
    a = 64'h00000003_00000004;
    issue(OPR_A, a, 64'h0, 4'd1);
    chk("t1_start", alu_start, 1);
    chk("t1_inA", alu_inA, a);
    chk("t1_opr", alu_opr, OPR_A);
    chk("t1_busy", busy, 1);
    alu_respond(1, a);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_data", rsp_data, a);
    chk("t1_err", rsp_err, 0);
    chk("t1_tag", rsp_tag, 1);
    accept_rsp();
    chk("t1_ops", ops_count, 1);

    // 2. Add, tag 5, done after 2 cycles
    a = 64'h00000003_00000004;
    b = 64'h00000001_00000002;
    r = {a[63:32] + b[63:32], a[31:0] + b[31:0]};
    issue(OPR_ADD, a, b, 4'd5);
    chk("t2_start", alu_start, 1);
    chk("t2_inB", alu_inB, b);
    alu_respond(2, r);
    chk("t2_valid", rsp_valid, 1);
    chk("t2_data", rsp_data, 64'h00000004_00000006);
    chk("t2_tag", rsp_tag, 5);
    accept_rsp();
    chk("t2_ops", ops_count, 2);

    // 3. Timeout: no done; 63 WAIT cycles, response 64 cycles after start
    issue(OPR_MODA, a, b, 4'd7);
    cnt = 0;
    while (!rsp_valid && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
    chk("t3_latency", cnt, 64);
    chk("t3_err", rsp_err, 1);
    chk("t3_data", rsp_data, 0);
    chk("t3_tag", rsp_tag, 7);
    chk("t3_errs", err_count, 1);
    accept_rsp();
    chk("t3_ops", ops_count, 2);

    // Done in the final WAIT cycle wins over timeout
    issue(OPR_MODB, a, b, 4'd8);
    alu_respond(63, 64'h12345678_9ABCDEF0);
    chk("t3b_valid", rsp_valid, 1);
    chk("t3b_err", rsp_err, 0);
    chk("t3b_data", rsp_data, 64'h12345678_9ABCDEF0);
    accept_rsp();
    chk("t3b_errs", err_count, 1);

    // Legal command after timeout completes normally
    r = {a[63:32] - b[63:32], a[31:0] - b[31:0]};
    issue(OPR_SUB, a, b, 4'd2);
    alu_respond(3, r);
    chk("t3c_data", rsp_data, 64'h00000002_00000002);
    chk("t3c_err", rsp_err, 0);
    accept_rsp();
    chk("t3c_ops", ops_count, 4);

    // 4. Illegal opcode
    issue(4'b0101, a, b, 4'd9);
    chk("t4_no_start", alu_start, 0);
    chk("t4_valid", rsp_valid, 1);
    chk("t4_err", rsp_err, 1);
    chk("t4_data", rsp_data, 0);
    chk("t4_tag", rsp_tag, 9);
    chk("t4_errs", err_count, 2);
    accept_rsp();
    chk("t4_ops", ops_count, 4);

    // 5. Backpressure for 10 cycles
    issue(OPR_MUL, a, b, 4'd3);
    alu_respond(1, 64'h00000001_0000000A);
    held_data = 64'h00000001_0000000A;
    for (int i = 0; i < 10; i++) begin
      chk("t5_valid_hold", rsp_valid, 1);
      chk("t5_data_hold", rsp_data, held_data);
      chk("t5_tag_hold", rsp_tag, 3);
      chk("t5_cmd_ready_low", cmd_ready, 0);
      @(negedge clock);
    end
    accept_rsp();
    chk("t5_ops", ops_count, 5);

    // 6. Reset three cycles after start
    issue(OPR_MODB, a, b, 4'd4);
    repeat (3) @(negedge clock);
    chk("t6_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_inA", alu_inA, 0);
    chk("t6_opr", alu_opr, 0);
    chk("t6_valid", rsp_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    chk("t6_ops", ops_count, 0);
    chk("t6_errs", err_count, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("t6_ready_pre_edge", cmd_ready, 0);
    @(negedge clock);
    chk("t6_ready_post_edge", cmd_ready, 1);
    chk("t6_no_rsp", rsp_valid, 0);

    // Recovery after reset
    a = 64'hFFFFFFFF_00000010;
    issue(OPR_B, 64'h0, a, 4'd6);
    alu_respond(1, a);
    chk("t6r_data", rsp_data, a);
    chk("t6r_tag", rsp_tag, 6);
    accept_rsp();
    chk("t6r_ops", ops_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/alux_issuer.md
Name: alux_issuer

Overview:
Initiator for the ALUX complex-number ALU's start/opr/done interface. It accepts tagged commands from an upstream controller over a valid/ready handshake. It drives inA/inB/opr and a one-cycle start pulse into the ALU, waits for done with a timeout, and returns the tagged 64-bit result downstream over valid/ready. Operands use the ALUX format: real part in [63:32], imaginary part in [31:0], two's complement.

Parameters:
DATA_W, 64, operand/result width (two 32-bit halves)
TAG_W, 4, command tag width, returned unchanged with the response
TIMEOUT, 63, max WAIT cycles before error (must exceed worst ALU latency, 38 for MOD/ANG)

Ports:
clock  in  1  master clock, posedge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  issuer can accept a command
cmd_opr  in  4  ALU opcode
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
cmd_tag  in  TAG_W  command tag
alu_inA  out  DATA_W  to ALU inA, held stable from ISSUE through WAIT
alu_inB  out  DATA_W  to ALU inB, held likewise
alu_opr  out  4  to ALU opr, held likewise
alu_start  out  1  one-cycle start pulse
alu_done  in  1  ALU done
alu_outAB  in  DATA_W  ALU registered result
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts response
rsp_data  out  DATA_W  result; 0 on error
rsp_tag  out  TAG_W  tag of the originating command
rsp_err  out  1  1 = illegal opcode or timeout
busy  out  1  state != IDLE
ops_count  out  16  completed good operations, wraps at 0xFFFF->0
err_count  out  8  error responses, saturates at 0xFF

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0, including cmd_ready, alu_* and counters.
  - cmd_ready rises on the first clock edge after reset deasserts.
- Legal opcodes: 0000 A, 0001 B, 0010 A+B, 0011 A-B, 0100 A*B, 0110 Re/Im products, 1000 A==B, 1001 mod/ang A, 1010 mod/ang B. All others are illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP. cmd_ready = (state==IDLE), registered.
- IDLE:
  - On cmd_valid&&cmd_ready, latch opr/a/b/tag.
  - Legal opcode: next state ISSUE; alu_inA/inB/opr load on the same edge.
  - Illegal opcode: next state RESP with rsp_err=1, rsp_data=0. No start pulse is issued.
- ISSUE:
  - alu_start=1 for exactly this one cycle; wait counter cleared.
  - alu_done sampled in ISSUE is ignored (stale); next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - If alu_done=1: capture alu_outAB into rsp_data, rsp_err=0, ops_count+1, next state RESP.
  - Else if counter==TIMEOUT: rsp_data=0, rsp_err=1, err_count+1 (saturating), next state RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid=1 with data/tag/err stable until rsp_ready=1; leave on that edge to IDLE.
  - Each transfer is one response.
- alu_inA/inB/opr hold their last value after returning to IDLE; they change only on the next accept.
- Latency: ALU done asserted N cycles after start (N>=1) gives rsp_valid N+1 cycles after the start cycle. An accepted command starts its pulse the cycle after the accept.
- Illegal opcode: rsp_valid appears 1 cycle after accept; err_count increments.
- Reset mid-operation (any state): abort to IDLE. No response is produced for the in-flight command, and counters clear.

Decomposition:
- Shared package alux_pkg holds:
  - opcode localparams (OPR_A, OPR_B, OPR_ADD, OPR_SUB, OPR_MUL, OPR_REIM, OPR_EQ, OPR_MODA, OPR_MODB);
  - the state encoding;
  - function is_legal_opr.
- One natural sub-module: alux_issuer_wdog, the WAIT counter and timeout compare (clear, enable, expired).

Test Plan:
1. Passthrough: cmd A, opr=0000, a=0x00000003_00000004, ALU model done 1 cycle after start -> rsp_data=0x00000003_00000004, rsp_err=0, rsp_valid 2 cycles after start, ops_count=1.
2. Add: opr=0010, a=0x00000003_00000004, b=0x00000001_00000002, tag=5, done after 2 cycles -> rsp_data=0x00000004_00000006, rsp_tag=5, alu_start high exactly 1 cycle.
3. Timeout: opr=1001, model never asserts done -> after 63 WAIT cycles rsp_err=1, rsp_data=0, err_count=1. A following legal command completes normally.
4. Illegal opcode: opr=0101 -> no alu_start, rsp_err=1 one cycle after accept, err_count increments.
5. Backpressure: rsp_ready low 10 cycles -> rsp_valid/data/tag stable, cmd_ready=0 throughout. Response is accepted on the first ready cycle, then cmd_ready=1.
6. Reset mid-WAIT: assert reset 3 cycles after start -> outputs 0 asynchronously, no rsp_valid, counters 0. cmd_ready=1 after the first post-reset edge.
